// File: rtl/fm_mon_arbiter_if.sv
// rtl/fm_mon_arbiter_if.sv - bus bundle for fm_mon_arbiter; out_ts exists only when FM_ARB_TIMESTAMP_EN is defined
interface fm_mon_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = (N_SRC > 2) ? $clog2(N_SRC) : 1
);
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_vld;
    logic [N_SRC-1:0]        src_mask;
    logic [DATA_W-1:0]       out_data;
    logic [SRC_W-1:0]        out_src;
    logic                    out_vld;
    logic                    out_ready;
    logic [N_SRC-1:0]        ovf_sticky;
    logic                    ovf_clr;
    logic [N_SRC-1:0]        fifo_empty;
`ifdef FM_ARB_TIMESTAMP_EN
    logic [15:0]             out_ts;
`endif

    modport master (
        output src_data, src_vld, src_mask, out_ready, ovf_clr,
        input  out_data, out_src, out_vld, ovf_sticky, fifo_empty
`ifdef FM_ARB_TIMESTAMP_EN
        , input out_ts
`endif
    );

    modport slave (
        input  src_data, src_vld, src_mask, out_ready, ovf_clr,
        output out_data, out_src, out_vld, ovf_sticky, fifo_empty
`ifdef FM_ARB_TIMESTAMP_EN
        , output out_ts
`endif
    );
endinterface

// File: rtl/fm_mon_arbiter.sv
// rtl/fm_mon_arbiter.sv - round-robin arbiter of N_SRC fm monitor streams into one channel; FM_ARB_TIMESTAMP_EN adds 16-bit capture timestamps
module fm_mon_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    fm_mon_arbiter_if.slave bus
);
    localparam int SRC_W = (N_SRC > 2) ? $clog2(N_SRC) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef FM_ARB_TIMESTAMP_EN
    localparam int TS_W    = 16;
    localparam int ENTRY_W = DATA_W + TS_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr [N_SRC];
    logic [PTR_W-1:0]   rd_ptr [N_SRC];
    logic [CNT_W-1:0]   count  [N_SRC];
    logic [ENTRY_W-1:0] wr_entry [N_SRC];
    logic [ENTRY_W-1:0] rd_entry;
    logic [N_SRC-1:0]   full, nonempty, push, pop, ovf_set, ovf_q;
    logic [SRC_W-1:0]   last_grant, gnt_idx, out_src_q;
    logic               gnt_found, pop_en;
    logic [DATA_W-1:0]  out_data_q;
`ifdef FM_ARB_TIMESTAMP_EN
    logic [TS_W-1:0]    ts_cnt, out_ts_q;
`endif

    // FIFO status derived from the registered occupancy counts
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            full[i]     = (count[i] == CNT_W'(FIFO_DEPTH));
            nonempty[i] = (count[i] != '0);
        end
    end

    // Round-robin search starting just after the last granted source
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!gnt_found && nonempty[(int'(last_grant) + k) % N_SRC]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'((int'(last_grant) + k) % N_SRC);
            end
        end
    end

    // Output stage next state: load when empty, reload on transfer, freeze on stall
    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (gnt_found) begin
                    pop_en  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    if (gnt_found) pop_en = 1'b1;
                    else           state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Decode the single pop onto the granted FIFO
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pop[i] = pop_en && (gnt_idx == SRC_W'(i));
        end
    end

    // Push acceptance and overflow detection; a pop frees the slot of a full FIFO this cycle
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            push[i]    = bus.src_vld[i] & bus.src_mask[i] & (~full[i] | pop[i]);
            ovf_set[i] = bus.src_vld[i] & bus.src_mask[i] & full[i] & ~pop[i];
`ifdef FM_ARB_TIMESTAMP_EN
            wr_entry[i] = {ts_cnt, bus.src_data[i*DATA_W +: DATA_W]};
`else
            wr_entry[i] = bus.src_data[i*DATA_W +: DATA_W];
`endif
        end
    end

    assign rd_entry = mem[gnt_idx][rd_ptr[gnt_idx]];

    // FIFO storage; contents need no reset because counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= wr_entry[i];
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

    // Output stage state and grant history; pointer starts at the top so source 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            last_grant <= SRC_W'(N_SRC - 1);
        end else begin
            state_q <= state_d;
            if (pop_en) last_grant <= gnt_idx;
        end
    end

    // Output register loads the popped entry together with its source tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            out_src_q  <= '0;
`ifdef FM_ARB_TIMESTAMP_EN
            out_ts_q   <= '0;
`endif
        end else if (pop_en) begin
            out_data_q <= rd_entry[DATA_W-1:0];
            out_src_q  <= gnt_idx;
`ifdef FM_ARB_TIMESTAMP_EN
            out_ts_q   <= rd_entry[ENTRY_W-1 -: TS_W];
`endif
        end
    end

    // Sticky overflow flags; a new overflow in the clear cycle keeps its bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_set | (ovf_q & ~{N_SRC{bus.ovf_clr}});
    end

`ifdef FM_ARB_TIMESTAMP_EN
    // Free-running capture counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + TS_W'(1);
    end

    assign bus.out_ts = out_ts_q;
`endif

    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_vld    = (state_q == S_HOLD);
    assign bus.ovf_sticky = ovf_q;
    assign bus.fifo_empty = ~nonempty;
endmodule
